rom_boot_loader: RTL and testbench
==================================

Name: rom_boot_loader

Overview:
- Sits between the mist_io ioctl download port and the sdram boot-write path.
- Turns the byte stream of ROM image index 0 into SDRAM boot writes, one byte per SDRAM reference slot (clkref), through a small FIFO.
- Holds system reset for the whole load and records which 16 KB pages were written.
- Flags dropped or out-of-range bytes.

Parameters:
- FIFO_DEPTH, 4, byte/address entries buffered between ioctl and SDRAM; power of two, minimum 2.
- HOLD_CYCLES, 16, clk_sys cycles boot_reset stays high after the FIFO drains.
- ROM_INDEX, 0, ioctl_index value treated as a ROM download.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download in progress
- ioctl_index  in  8  image type
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte offset in image
- ioctl_dout  in  8  byte data
- clkref  in  1  SDRAM slot strobe; a write is taken when boot_wr & clkref
- boot_wr  out  1  write request to SDRAM
- boot_a  out  23  SDRAM byte address
- boot_bank  out  2  SDRAM bank
- boot_dout  out  8  write data
- boot_reset  out  1  hold machine in reset
- pages_loaded  out  8  sticky bit per 16 KB image page 0..7 written
- overrun  out  1  sticky: byte dropped because the FIFO was full
- range_err  out  1  sticky: byte with page >= 8 ignored

Behaviour:
- Reset values: all outputs 0; FIFO empty; FSM in IDLE.
- rom_dl = ioctl_download & (ioctl_index == ROM_INDEX).
- Address map: page = ioctl_addr[24:14], boot_a[13:0] = ioctl_addr[13:0].
  - page 0,4 -> boot_a[22:14] = 9'h000
  - page 1,5 -> 9'h100
  - page 2,6 -> 9'h107
  - page 3,7 -> 9'h1ff
  - boot_bank = 0 for pages 0-3, 1 for pages 4-7.
  - Page >= 8: byte is not pushed and range_err is set.
- Push: ioctl_wr & rom_dl & page < 8 & FIFO not full pushes {addr, bank, data} on that edge and sets pages_loaded[page].
  - Same push condition with FIFO full: byte dropped, overrun set.
- Pop: boot_wr = FIFO not empty and state is LOAD or DRAIN. boot_a, boot_bank and boot_dout present the FIFO head combinationally.
  - The entry pops on the edge where boot_wr & clkref.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
- FSM:
  - IDLE: rising edge of rom_dl -> LOAD. On entry, clear pages_loaded, overrun and range_err; set boot_reset = 1.
  - LOAD: rom_dl falls -> DRAIN.
  - DRAIN: FIFO empty -> HOLD, load hold counter with HOLD_CYCLES-1. A new rom_dl rising edge in DRAIN -> LOAD; sticky flags are not cleared.
  - HOLD: counter decrements each cycle; at 0 -> IDLE with boot_reset = 0. A rom_dl rising edge in HOLD -> LOAD and clears sticky flags.
- boot_reset is 1 in LOAD, DRAIN and HOLD, and 0 in IDLE.
- Latency: a byte pushed into an empty FIFO is visible on boot_wr the next cycle. Best-case throughput is one byte per clkref.
- Downloads with ioctl_index != ROM_INDEX are ignored entirely; no state change.
- reset mid-operation: FIFO flushed, FSM to IDLE, boot_reset drops at once. Bytes not yet written are lost.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap; occupancy counter is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package amstrad_boot_pkg:
  - page-to-base mapping function
  - boot_entry_t struct {a[22:0], bank[1:0], d[7:0]}
  - FSM state enum {IDLE, LOAD, DRAIN, HOLD}
- One sub-module: boot_fifo, a synchronous FIFO of boot_entry_t with push, pop, full, empty and head.

Test Plan:
- Load 4 bytes at ioctl_addr 0x0000-0x0003, clkref every 16 cycles -> 4 writes at boot_a 0x000000-0x000003, bank 0. pages_loaded = 8'h01. boot_reset falls exactly HOLD_CYCLES cycles after the last write.
- Single byte at ioctl_addr 0x14005 -> boot_a = {9'h100, 14'h0005}, bank 1, pages_loaded = 8'h20.
- 6 back-to-back ioctl_wr with clkref held low (depth 4) -> 4 entries stored, overrun = 1. After clkref resumes, exactly 4 writes occur.
- Byte at ioctl_addr 0x20000 (page 8) -> no boot_wr, range_err = 1, pages_loaded unchanged.
- Download with ioctl_index = 1 -> boot_reset stays 0, no writes.
- Assert reset with 2 entries pending -> boot_wr = 0 and boot_reset = 0 next cycle; FIFO empty; a following download starts cleanly from IDLE.

Source files
------------

// File: rtl/amstrad_boot_pkg.sv
// amstrad_boot_pkg: shared types and page mapping for the ROM boot loader
package amstrad_boot_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;
  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  bank;
    logic [7:0]  d;
  } boot_entry_t;
  // SDRAM row base for a 16 KB image page; pages 4-7 reuse these bases in bank 1
  function automatic logic [8:0] page_base(input logic [1:0] p);
    return p == 2'd0 ? 9'h000 : p == 2'd1 ? 9'h100 : p == 2'd2 ? 9'h107 : 9'h1ff;
  endfunction
endpackage

// File: rtl/boot_fifo.sv
// boot_fifo: synchronous FIFO of boot entries with wrapping pointers
module boot_fifo
  import amstrad_boot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  boot_entry_t              din_i,
  output boot_entry_t              head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  boot_entry_t mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] count_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wp_q] <= din_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_q + AW'(push_i);
      rp_q    <= rp_q + AW'(pop_i);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign head_o  = mem_q[rp_q];
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
endmodule

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: turns ioctl ROM downloads into clkref-paced SDRAM boot writes
// while holding the machine in reset and tracking loaded pages and errors.
module rom_boot_loader
  import amstrad_boot_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         HOLD_CYCLES = 16,
  parameter logic [7:0] ROM_INDEX   = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        clkref,
  output logic        boot_wr,
  output logic [22:0] boot_a,
  output logic [1:0]  boot_bank,
  output logic [7:0]  boot_dout,
  output logic        boot_reset,
  output logic [7:0]  pages_loaded,
  output logic        overrun,
  output logic        range_err
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic rom_dl, rom_dl_q, rise, in_rng, push, pop, full, empty, drained, clr;
  logic [$clog2(FIFO_DEPTH):0] count;
  boot_entry_t din, head;
  assign rom_dl  = ioctl_download & (ioctl_index == ROM_INDEX);
  assign rise    = rom_dl & ~rom_dl_q;
  assign in_rng  = ioctl_addr[24:17] == '0;
  assign push    = ioctl_wr & rom_dl & in_rng & ~full;
  assign boot_wr = ~empty & (state_q == LOAD | state_q == DRAIN);
  assign pop     = boot_wr & clkref;
  assign din     = {page_base(ioctl_addr[15:14]), ioctl_addr[13:0], 1'b0, ioctl_addr[16], ioctl_dout};
  // FIFO is empty after this edge: lets HOLD start on the last write itself
  assign drained = empty | (count == 1 & pop & ~push);
  assign clr     = rise & (state_q == IDLE | state_q == HOLD);
  assign boot_reset = state_q != IDLE;
  assign boot_a    = head.a;
  assign boot_bank = head.bank;
  assign boot_dout = head.d;
  boot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk_sys),
    .rst    (reset),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (din),
    .head_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(count)
  );
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rom_dl_q     <= 1'b0;
      pages_loaded <= '0;
      overrun      <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      rom_dl_q     <= rom_dl;
      pages_loaded <= (clr ? 8'h00 : pages_loaded) | (push ? 8'(1) << ioctl_addr[16:14] : 8'h00);
      overrun      <= (~clr & overrun) | (ioctl_wr & rom_dl & in_rng & full);
      range_err    <= (~clr & range_err) | (ioctl_wr & rom_dl & ~in_rng);
      case (state_q)
        IDLE:  if (rise) state_q <= LOAD;
        LOAD:  if (~rom_dl) state_q <= DRAIN;
        DRAIN: if (rise) state_q <= LOAD;
               else if (drained) begin
                 state_q <= HOLD;
                 cnt_q   <= CW'(HOLD_CYCLES - 1);
               end
        HOLD:  if (rise) state_q <= LOAD;
               else if (cnt_q == '0) state_q <= IDLE;
               else cnt_q <= cnt_q - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_boot_loader.sv
// tb_rom_boot_loader: randomized scoreboard bench for rom_boot_loader
module tb_rom_boot_loader;
  localparam int DEPTH = 4;
  localparam int HOLD  = 16;
  localparam logic [8:0] BASE [4] = '{9'h000, 9'h100, 9'h107, 9'h1ff};
  logic clk = 0, reset = 1, ioctl_download = 0, ioctl_wr = 0, clkref = 0;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0;
  logic [24:0] ioctl_addr = 0;
  logic boot_wr, boot_reset, overrun, range_err;
  logic [22:0] boot_a;
  logic [1:0] boot_bank;
  logic [7:0] boot_dout, pages_loaded;
  int cyc = 0, checks = 0, errors = 0, nw = 0, last_pop = 0, dl_off = 0, ph = 0, cr_per = 1;
  bit cr_en = 1;
  logic [32:0] q[$];
  logic [24:0] addrs[$];
  logic [7:0] exp_pages = 0;
  logic exp_ov = 0, exp_re = 0;

  rom_boot_loader #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .ROM_INDEX(8'd0)) dut (
    .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .clkref(clkref),
    .boot_wr(boot_wr), .boot_a(boot_a), .boot_bank(boot_bank), .boot_dout(boot_dout),
    .boot_reset(boot_reset), .pages_loaded(pages_loaded), .overrun(overrun), .range_err(range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model_entry(input logic [24:0] a, input logic [7:0] d);
    int pg;
    pg = int'(a[24:14]);
    return {BASE[pg % 4], a[13:0], 2'(pg / 4), d};
  endfunction

  // scoreboard monitor: every accepted SDRAM write must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && boot_wr) begin
      chk("wr_outside_reset_hold", boot_reset, 1);
      if (clkref) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %0h expected none", {boot_a, boot_bank, boot_dout});
        end else chk("write_entry", {boot_a, boot_bank, boot_dout}, q.pop_front());
        nw++;
        last_pop = cyc + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
    clkref = cr_en && (ph % cr_per == 0);
  endtask

  task automatic dl(input logic [7:0] idx, input int gapmax);
    bit rom, lat;
    logic [10:0] pg;
    rom = idx == 8'd0;
    ioctl_index = idx;
    ioctl_download = 1;
    if (rom) begin
      exp_pages = 0;
      exp_ov = 0;
      exp_re = 0;
      last_pop = 0;
    end
    tick();
    foreach (addrs[i]) begin
      lat = 0;
      pg = addrs[i][24:14];
      ioctl_addr = addrs[i];
      ioctl_dout = 8'($urandom);
      ioctl_wr = 1;
      if (rom) begin
        if (pg >= 8) exp_re = 1;
        else if (q.size() >= DEPTH) exp_ov = 1;
        else begin
          lat = q.size() == 0;
          q.push_back(model_entry(addrs[i], ioctl_dout));
          exp_pages[pg[2:0]] = 1;
        end
      end
      tick();
      ioctl_wr = 0;
      if (lat) chk("first_byte_latency", boot_wr, 1);
      repeat ($urandom_range(0, gapmax)) tick();
    end
    ioctl_download = 0;
    dl_off = cyc + 1;
    tick();
  endtask

  task automatic check_flags();
    chk("pages_loaded", pages_loaded, exp_pages);
    chk("overrun", overrun, exp_ov);
    chk("range_err", range_err, exp_re);
  endtask

  task automatic finish_rom();
    int t;
    t = 0;
    cr_en = 1;
    while (boot_reset === 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    chk("boot_reset_release", boot_reset, 0);
    chk("hold_timing", cyc, (last_pop > dl_off + 1 ? last_pop : dl_off + 1) + HOLD);
    chk("all_bytes_written", q.size(), 0);
    check_flags();
  endtask

  initial begin
    int n0;
    logic [10:0] pg;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_boot_wr", boot_wr, 0);
    chk("rst_boot_reset", boot_reset, 0);
    chk("rst_pages", pages_loaded, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_range_err", range_err, 0);

    // four sequential bytes, one SDRAM slot every 16 cycles
    cr_per = 16;
    n0 = nw;
    addrs = '{25'h0, 25'h1, 25'h2, 25'h3};
    dl(0, 0);
    finish_rom();
    chk("t1_writes", nw - n0, 4);
    chk("t1_pages", pages_loaded, 8'h01);

    // single byte in page 5
    cr_per = 3;
    addrs = '{25'h14005};
    dl(0, 0);
    finish_rom();
    chk("t2_pages", pages_loaded, 8'h20);

    // six back-to-back bytes while SDRAM slots are withheld
    cr_en = 0;
    cr_per = 2;
    n0 = nw;
    addrs = '{25'h100, 25'h101, 25'h102, 25'h103, 25'h104, 25'h105};
    dl(0, 0);
    chk("t3_no_early_writes", nw - n0, 0);
    finish_rom();
    chk("t3_writes", nw - n0, 4);
    chk("t3_overrun", overrun, 1);

    // page 8 is out of range
    n0 = nw;
    addrs = '{25'h20000};
    dl(0, 0);
    finish_rom();
    chk("t4_writes", nw - n0, 0);
    chk("t4_range_err", range_err, 1);

    // non-ROM image index is ignored
    n0 = nw;
    addrs = '{25'h10, 25'h11};
    dl(8'd1, 0);
    chk("t5_boot_reset", boot_reset, 0);
    repeat (5) tick();
    chk("t5_writes", nw - n0, 0);
    check_flags();

    // reset with two entries pending
    cr_en = 0;
    addrs = '{25'h40, 25'h41};
    dl(0, 0);
    reset = 1;
    tick();
    chk("t6_boot_wr", boot_wr, 0);
    chk("t6_boot_reset", boot_reset, 0);
    chk("t6_pages", pages_loaded, 0);
    q.delete();
    exp_pages = 0;
    exp_ov = 0;
    exp_re = 0;
    reset = 0;
    tick();
    cr_en = 1;
    cr_per = 1;
    n0 = nw;
    addrs = '{25'h8001};
    dl(0, 0);
    finish_rom();
    chk("t6_clean_writes", nw - n0, 1);

    // randomized downloads
    for (int k = 0; k < 25; k++) begin
      logic [7:0] idx;
      addrs.delete();
      for (int j = 0; j < $urandom_range(1, 8); j++) begin
        pg = ($urandom_range(0, 99) < 15) ? 11'($urandom_range(8, 2047)) : 11'($urandom_range(0, 7));
        addrs.push_back({pg, 14'($urandom)});
      end
      idx = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      cr_per = $urandom_range(1, 5);
      cr_en = 1;
      dl(idx, 2);
      if (idx == 8'd0) finish_rom();
      else begin
        chk("rand_ignored_reset", boot_reset, 0);
        check_flags();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
